bcd_binary_encoder: RTL and testbench
=====================================

BCD_BINARY_ENCODER -- requirements
Module: bcd_binary_encoder

Interface
REQ-001 SHALL have port clk_i, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-003 SHALL have port start_i, input, 1 bit: request a conversion of the digits now on tens_i/ones_i.
REQ-004 SHALL have port tens_i, input, 4 bits: BCD tens digit.
REQ-005 SHALL have port ones_i, input, 4 bits: BCD ones digit.
REQ-006 SHALL have port max_i, input, 6 bits: inclusive upper limit for the result, e.g. 59 for min/sec, 23 for hours.
REQ-007 SHALL have port binary_o, output reg, 6 bits: last accepted binary value.
REQ-008 SHALL have port valid_o, output reg, 1 bit: one-cycle pulse when binary_o has been updated.
REQ-009 SHALL have port error_o, output reg, 1 bit: one-cycle pulse on a rejected conversion.
REQ-010 SHALL have port busy_o, output reg, 1 bit: high while a conversion is in flight.

Function
REQ-011 SHALL implement FSM states IDLE, CHECK, MUL, ADD, RANGE.
- IDLE -> CHECK when start_i=1; the other transitions are unconditional, with RANGE -> IDLE.
REQ-012 SHALL, on the edge where the FSM is in IDLE and start_i=1, latch tens_i, ones_i and max_i, and set busy_o=1.
REQ-013 SHALL ignore start_i whenever busy_o=1; the latched operands SHALL NOT change mid-conversion.
REQ-014 SHALL, in CHECK, flag a digit error if the latched tens>9 or ones>9.
REQ-015 SHALL, in MUL, compute acc = (tens<<3) + (tens<<1) into a 7-bit accumulator.
REQ-016 SHALL, in ADD, compute acc = acc + ones; the maximum is 99, so 7 bits SHALL NOT overflow.
REQ-017 SHALL, in RANGE, compare acc > latched max_i as a 7-bit compare.
REQ-018 SHALL, on the edge leaving RANGE, produce exactly one of the following, then clear busy_o and return to IDLE:
- valid_o=1 with binary_o=acc[5:0]; or
- error_o=1 with binary_o unchanged.
REQ-019 SHALL give a fixed latency: with start accepted at edge k, valid_o or error_o is high during the cycle following edge k+4, for exactly one cycle.
REQ-020 SHALL give a digit error priority over range handling; a digit error always yields error_o=1, in both configurations.
REQ-021 SHALL never assert valid_o and error_o in the same cycle.
REQ-022 SHALL allow back-to-back operation: start_i=1 in the first IDLE cycle after completion is accepted.
REQ-023 SHALL treat acc == max_i as in range, and acc=0 as valid.

Reset
REQ-024 SHALL, on rst_i=1 at a clock edge, set state=IDLE, binary_o=0, valid_o=0, error_o=0, busy_o=0, and clear the latched operands and acc.
REQ-025 SHALL let rst_i override start_i; a reset mid-conversion aborts it with no valid_o or error_o pulse.

Configuration
REQ-026 SHALL provide the macro BCD_SATURATE_EN.
- Defined: a range violation with valid digits gives binary_o = latched max_i, valid_o=1, error_o=0.
- Undefined: a range violation gives error_o=1 with binary_o unchanged.
- Digit-error behaviour is identical in both configurations.

Verification
REQ-027 SHALL cover: reset, then tens=4, ones=7, max=59, start pulse -> busy for 4 cycles, then valid_o pulse, binary_o=47.
REQ-028 SHALL cover: tens=5, ones=9, max=59 -> binary_o=59, valid_o; then tens=0, ones=0 -> binary_o=0, valid_o.
REQ-029 SHALL cover: tens=6, ones=0, max=59:
- without the macro -> error_o pulse, binary_o stays 0;
- with BCD_SATURATE_EN -> valid_o, binary_o=59.
REQ-030 SHALL cover: tens=0xA, ones=3, max=63 -> error_o pulse in both configurations, binary_o unchanged.
REQ-031 SHALL cover: start with tens=2, ones=3, max=23; change the inputs and pulse start_i at cycle 2 -> binary_o=23, with exactly one completion pulse.
REQ-032 SHALL cover: start with tens=1, ones=2; assert rst_i at cycle 2 -> no valid_o or error_o pulse, busy_o=0, binary_o=0.

Source files
------------

// File: rtl/bcd_binary_encoder.sv
// Two-digit BCD to 6-bit binary converter with an inclusive upper limit check.
// Optional macro BCD_SATURATE_EN clamps out-of-range results to the limit instead of flagging them.
module bcd_binary_encoder (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [3:0] tens_i,
    input  logic [3:0] ones_i,
    input  logic [5:0] max_i,
    output logic [5:0] binary_o,
    output logic       valid_o,
    output logic       error_o,
    output logic       busy_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        MUL   = 3'd2,
        ADD   = 3'd3,
        RANGE = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] tens_q, tens_d;
    logic [3:0] ones_q, ones_d;
    logic [5:0] max_q, max_d;
    logic [6:0] acc_q, acc_d;
    logic       dig_err_q, dig_err_d;
    logic [5:0] binary_q, binary_d;
    logic       valid_q, valid_d;
    logic       error_q, error_d;
    logic       busy_q, busy_d;

    // Next-state and next-output computation for the conversion sequence.
    always_comb begin
        state_d   = state_q;
        tens_d    = tens_q;
        ones_d    = ones_q;
        max_d     = max_q;
        acc_d     = acc_q;
        dig_err_d = dig_err_q;
        binary_d  = binary_q;
        valid_d   = 1'b0;
        error_d   = 1'b0;
        busy_d    = busy_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    tens_d    = tens_i;
                    ones_d    = ones_i;
                    max_d     = max_i;
                    dig_err_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = CHECK;
                end else begin
                    busy_d    = 1'b0;
                end
            end
            CHECK: begin
                dig_err_d = (tens_q > 4'd9) || (ones_q > 4'd9);
                state_d   = MUL;
            end
            MUL: begin
                // tens*10 as shift-and-add; only meaningful for valid digits.
                acc_d   = ({3'b000, tens_q} << 3) + ({3'b000, tens_q} << 1);
                state_d = ADD;
            end
            ADD: begin
                acc_d   = acc_q + {3'b000, ones_q};
                state_d = RANGE;
            end
            RANGE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
                if (dig_err_q) begin
                    error_d = 1'b1;
                end else if (acc_q > {1'b0, max_q}) begin
`ifdef BCD_SATURATE_EN
                    binary_d = max_q;
                    valid_d  = 1'b1;
`else
                    error_d  = 1'b1;
`endif
                end else begin
                    binary_d = acc_q[5:0];
                    valid_d  = 1'b1;
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State, operand and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            tens_q    <= 4'd0;
            ones_q    <= 4'd0;
            max_q     <= 6'd0;
            acc_q     <= 7'd0;
            dig_err_q <= 1'b0;
            binary_q  <= 6'd0;
            valid_q   <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tens_q    <= tens_d;
            ones_q    <= ones_d;
            max_q     <= max_d;
            acc_q     <= acc_d;
            dig_err_q <= dig_err_d;
            binary_q  <= binary_d;
            valid_q   <= valid_d;
            error_q   <= error_d;
            busy_q    <= busy_d;
        end
    end

    assign binary_o = binary_q;
    assign valid_o  = valid_q;
    assign error_o  = error_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_bcd_binary_encoder.sv
// Self-checking bench for bcd_binary_encoder: directed table, hand-written corner sequences,
// and randomized conversions against an arithmetic reference model.
module tb_bcd_binary_encoder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic [5:0] maxv = 6'd0;
    logic [5:0] binary_o;
    logic       valid_o;
    logic       error_o;
    logic       busy_o;

    int errors = 0;
    int checks = 0;
    int model_bin = 0;

`ifdef BCD_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    localparam int K_VALID = 1;
    localparam int K_ERROR = 2;

    typedef struct {
        int t;
        int o;
        int m;
        int kind;
        int bin;
    } vec_t;

    vec_t tbl[8];

    bcd_binary_encoder dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start),
        .tens_i  (tens),
        .ones_i  (ones),
        .max_i   (maxv),
        .binary_o(binary_o),
        .valid_o (valid_o),
        .error_o (error_o),
        .busy_o  (busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: value = 10*tens + ones; digit errors first, then inclusive limit.
    task automatic model(input int t, input int o, input int m, input int prev,
                         output int kind, output int bin);
        int v;
        v = t * 10 + o;
        if (t > 9 || o > 9) begin
            kind = K_ERROR;
            bin  = prev;
        end else if (v > m) begin
            kind = SAT ? K_VALID : K_ERROR;
            bin  = SAT ? m : prev;
        end else begin
            kind = K_VALID;
            bin  = v;
        end
    endtask

    // Called at a negedge; returns at the negedge after the completion edge.
    task automatic run_conv(input int t, input int o, input int m, input int kind, input int bin);
        tens  = 4'(t);
        ones  = 4'(o);
        maxv  = 6'(m);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("busy_during", int'(busy_o), 1);
            chk("no_pulse_during", int'(valid_o) + int'(error_o), 0);
            @(posedge clk);
            @(negedge clk);
        end
        chk("valid_pulse", int'(valid_o), kind == K_VALID ? 1 : 0);
        chk("error_pulse", int'(error_o), kind == K_ERROR ? 1 : 0);
        chk("binary_out", int'(binary_o), bin);
        chk("busy_done", int'(busy_o), 0);
    endtask

    initial begin
        int kind;
        int bin;
        int pulses;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_binary", int'(binary_o), 0);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_error", int'(error_o), 0);
        chk("rst_busy", int'(busy_o), 0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);

        tbl[0] = '{4, 7, 59, K_VALID, 47};
        tbl[1] = '{5, 9, 59, K_VALID, 59};
        tbl[2] = '{0, 0, 59, K_VALID, 0};
        tbl[3] = '{6, 0, 59, SAT ? K_VALID : K_ERROR, SAT ? 59 : 0};
        tbl[4] = '{10, 3, 63, K_ERROR, SAT ? 59 : 0};
        tbl[5] = '{2, 3, 23, K_VALID, 23};
        tbl[6] = '{9, 9, 63, SAT ? K_VALID : K_ERROR, SAT ? 63 : 23};
        tbl[7] = '{3, 15, 63, K_ERROR, SAT ? 63 : 23};

        // Back-to-back: each call starts on the first IDLE cycle after the previous one.
        for (int i = 0; i < 8; i++) begin
            run_conv(tbl[i].t, tbl[i].o, tbl[i].m, tbl[i].kind, tbl[i].bin);
        end
        model_bin = tbl[7].bin;
        @(posedge clk);
        @(negedge clk);
        chk("pulse_one_cycle", int'(valid_o) + int'(error_o), 0);

        // Start ignored while busy; operands held.
        tens = 4'd2; ones = 4'd3; maxv = 6'd23; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        tens = 4'd9; ones = 4'd9; maxv = 6'd10; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            pulses += int'(valid_o) + int'(error_o);
            if (i == 1) begin
                chk("midstart_valid", int'(valid_o), 1);
                chk("midstart_binary", int'(binary_o), 23);
            end
        end
        chk("midstart_pulses", pulses, 1);
        model_bin = 23;

        // Reset mid-conversion aborts silently.
        tens = 4'd1; ones = 4'd2; maxv = 6'd59; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        chk("abort_busy", int'(busy_o), 0);
        chk("abort_binary", int'(binary_o), 0);
        for (int i = 0; i < 8; i++) begin
            pulses += int'(valid_o) + int'(error_o) + int'(busy_o);
            @(posedge clk);
            @(negedge clk);
        end
        chk("abort_no_activity", pulses, 0);
        model_bin = 0;

        // Randomized conversions against the reference model.
        for (int i = 0; i < 60; i++) begin
            int t;
            int o;
            int m;
            t = int'($urandom_range(0, 11));
            o = int'($urandom_range(0, 11));
            m = (i % 10 == 0) ? 0 : int'($urandom_range(0, 63));
            model(t, o, m, model_bin, kind, bin);
            run_conv(t, o, m, kind, bin);
            model_bin = bin;
            if (i % 3 == 0) begin
                @(posedge clk);
                @(negedge clk);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
